// File: rtl/sa_test_pkg.sv
// Shared types and constants for the systolic-array test sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sa_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOAD_I = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_CHECK  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam int DEF_ROWS        = 4;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_OUT_W       = 32;
    localparam int DEF_INST_DEPTH  = 8;
    localparam int DEF_INST_W      = 4;
    localparam int DEF_MAX_N       = 8;
    localparam int DEF_TIMEOUT_CYC = 65535;

    // Source ROM layout: A operands, B operands, instructions, expected results.
    localparam int SRC_A_BASE     = 0;
    localparam int DEF_SRC_B_BASE = DEF_ROWS * DEF_DEPTH;
    localparam int DEF_SRC_I_BASE = 2 * DEF_ROWS * DEF_DEPTH;
    localparam int DEF_SRC_E_BASE = 2 * DEF_ROWS * DEF_DEPTH + DEF_INST_DEPTH;

    function automatic int src_b_base(input int rows, input int depth);
        return rows * depth;
    endfunction

    function automatic int src_i_base(input int rows, input int depth);
        return 2 * rows * depth;
    endfunction

    function automatic int src_e_base(input int rows, input int depth, input int inst_depth);
        return 2 * rows * depth + inst_depth;
    endfunction

    function automatic int src_words(input int rows, input int depth, input int inst_depth,
                                     input int max_n);
        return src_e_base(rows, depth, inst_depth) + max_n * rows * rows;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sa_result_cmp.sv
// Result comparator: counts matching words and latches the index of the first mismatch.
// Latency: counters update on the clock edge after vld.
// Backpressure: none; accepts one compare per cycle.
// Ports: clr restarts counting; vld/expected/actual/idx describe one compare;
//        match_count and first_err_idx (all-ones = no mismatch seen) are registered.
module sa_result_cmp #(
    parameter int OUT_W = 32,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             vld,
    input  logic [OUT_W-1:0] expected,
    input  logic [OUT_W-1:0] actual,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W:0]   match_count,
    output logic [IDX_W:0]   first_err_idx
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count   <= '0;
            first_err_idx <= '1;
        end else if (clr) begin
            match_count   <= '0;
            first_err_idx <= '1;
        end else if (vld) begin
            if (expected == actual) begin
                match_count <= match_count + 1'b1;
            end else if (first_err_idx == '1) begin
                // idx is one bit narrower, so a real index never looks like "none"
                first_err_idx <= {1'b0, idx};
            end
        end
    end

endmodule

// File: rtl/sa_test_sequencer.sv
// Test sequencer: loads A/B/instructions from a source ROM into a systolic-array DUT, starts it, checks results.
// Latency: 2*ROWS*DEPTH + INST_DEPTH + 4 cycles to ap_start, then WAIT, then NRES+1 check cycles.
// Backpressure: none; go while busy is ignored, WAIT is bounded by TIMEOUT_CYC.
// Ports: go/n_mat start a run; src_* read the ROM (latency 1); addr/data/en A,B,I write the DUT;
//        ap_start/ap_done handshake the DUT; addrO/dataO read results (latency 1); busy/done/pass/
//        timeout/match_count/first_err_idx report status, held in DONE until the next go.
module sa_test_sequencer
    import sa_test_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int INST_DEPTH  = DEF_INST_DEPTH,
    parameter int INST_W      = DEF_INST_W,
    parameter int MAX_N       = DEF_MAX_N,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int SA_W = $clog2(src_words(ROWS, DEPTH, INST_DEPTH, MAX_N)),
    localparam int OA_W = $clog2(ROWS * DEPTH),
    localparam int IA_W = $clog2(INST_DEPTH),
    localparam int RA_W = $clog2(MAX_N * ROWS * ROWS),
    localparam int MC_W = RA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [3:0]        n_mat,
    output logic [SA_W-1:0]   src_addr,
    input  logic [OUT_W-1:0]  src_data,
    output logic [OA_W-1:0]   addrA,
    output logic [DATA_W-1:0] dataA,
    output logic              enA,
    output logic [OA_W-1:0]   addrB,
    output logic [DATA_W-1:0] dataB,
    output logic              enB,
    output logic [IA_W-1:0]   addrI,
    output logic [INST_W-1:0] dataI,
    output logic              enI,
    output logic              ap_start,
    input  logic              ap_done,
    output logic [RA_W-1:0]   addrO,
    input  logic [OUT_W-1:0]  dataO,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [MC_W-1:0]   match_count,
    output logic [MC_W-1:0]   first_err_idx
);

    localparam int OPW     = ROWS * DEPTH;
    localparam int RES_MAX = MAX_N * ROWS * ROWS;
    localparam int B_BASE  = src_b_base(ROWS, DEPTH);
    localparam int I_BASE  = src_i_base(ROWS, DEPTH);
    localparam int E_BASE  = src_e_base(ROWS, DEPTH, INST_DEPTH);
    localparam int CNT_MAX = max_int(max_int(OPW, INST_DEPTH), max_int(RES_MAX, TIMEOUT_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [MC_W-1:0]  nres;
    logic [MC_W-1:0]  nres_calc;
    logic             timeout_q;
    logic             start_req;
    logic             clr_status;
    logic             cmp_vld;
    logic [RA_W-1:0]  cmp_idx;

    assign start_req  = (state == S_IDLE) && go;
    assign clr_status = go && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        if (int'(n_mat) > MAX_N) begin
            nres_calc = MC_W'(MAX_N * ROWS * ROWS);
        end else begin
            nres_calc = MC_W'(int'(n_mat) * ROWS * ROWS);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (go) state_nxt = S_LOAD_A;
            S_LOAD_A: if (cnt == CNT_W'(OPW)) state_nxt = S_LOAD_B;
            S_LOAD_B: if (cnt == CNT_W'(OPW)) state_nxt = S_LOAD_I;
            S_LOAD_I: if (cnt == CNT_W'(INST_DEPTH)) state_nxt = S_START;
            S_START:  state_nxt = S_WAIT;
            S_WAIT: begin
                // A completion on the final allowed cycle still wins over the timeout
                if (ap_done) begin
                    state_nxt = S_CHECK;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_CHECK:  if (cnt == CNT_W'(nres)) state_nxt = S_DONE;
            S_DONE:   if (go) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Per-state cycle counter, restarted on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if ((state_nxt != state) || (state == S_IDLE) || (state == S_DONE)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nres      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_req) begin
                nres <= nres_calc;
            end
            if (clr_status) begin
                timeout_q <= 1'b0;
            end else if ((state == S_WAIT) && (state_nxt == S_DONE)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Outputs: address issued at cnt, the matching write/compare lands at cnt+1
    always_comb begin
        src_addr = '0;
        addrA    = '0;
        dataA    = '0;
        enA      = 1'b0;
        addrB    = '0;
        dataB    = '0;
        enB      = 1'b0;
        addrI    = '0;
        dataI    = '0;
        enI      = 1'b0;
        ap_start = 1'b0;
        addrO    = '0;
        cmp_vld  = 1'b0;
        cmp_idx  = '0;
        unique case (state)
            S_LOAD_A: begin
                if (cnt < CNT_W'(OPW)) src_addr = SA_W'(SRC_A_BASE) + SA_W'(cnt);
                if (cnt != '0) begin
                    enA   = 1'b1;
                    addrA = OA_W'(cnt - CNT_W'(1));
                    dataA = src_data[DATA_W-1:0];
                end
            end
            S_LOAD_B: begin
                if (cnt < CNT_W'(OPW)) src_addr = SA_W'(B_BASE) + SA_W'(cnt);
                if (cnt != '0) begin
                    enB   = 1'b1;
                    addrB = OA_W'(cnt - CNT_W'(1));
                    dataB = src_data[DATA_W-1:0];
                end
            end
            S_LOAD_I: begin
                if (cnt < CNT_W'(INST_DEPTH)) src_addr = SA_W'(I_BASE) + SA_W'(cnt);
                if (cnt != '0) begin
                    enI   = 1'b1;
                    addrI = IA_W'(cnt - CNT_W'(1));
                    dataI = src_data[INST_W-1:0];
                end
            end
            S_START: ap_start = 1'b1;
            S_CHECK: begin
                if (cnt < CNT_W'(nres)) begin
                    addrO    = RA_W'(cnt);
                    src_addr = SA_W'(E_BASE) + SA_W'(cnt);
                end
                if (cnt != '0) begin
                    cmp_vld = 1'b1;
                    cmp_idx = RA_W'(cnt - CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE) && (state != S_DONE);
    assign done    = (state == S_DONE);
    assign timeout = timeout_q;
    assign pass    = (state == S_DONE) && !timeout_q && (match_count == nres);

    sa_result_cmp #(
        .OUT_W (OUT_W),
        .IDX_W (RA_W)
    ) u_cmp (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr_status),
        .vld           (cmp_vld),
        .expected      (src_data),
        .actual        (dataO),
        .idx           (cmp_idx),
        .match_count   (match_count),
        .first_err_idx (first_err_idx)
    );

endmodule

// File: doc/sa_test_sequencer.md
SA_TEST_SEQUENCER -- requirements
Module: sa_test_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 4: systolic array edge size; one result matrix is ROWS*ROWS words.
REQ-002 SHALL have parameter DEPTH, default 256: columns per row of operand memories A/B.
REQ-003 SHALL have parameter DATA_W, default 16: operand word width.
REQ-004 SHALL have parameter OUT_W, default 32: result and source-ROM word width.
REQ-005 SHALL have parameter INST_DEPTH, default 8, and INST_W, default 4: instruction memory depth and width.
REQ-006 SHALL have parameter MAX_N, default 8, and TIMEOUT_CYC, default 65535: max matrices checked; ap_done wait limit.
REQ-007 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle start request.
- n_mat  in  4  number of result matrices to check.
- src_addr  out  clog2(SRC_WORDS)  source ROM address, read latency 1 cycle.
- src_data  in  OUT_W  source ROM data.
- addrA/addrB  out  clog2(ROWS*DEPTH)  DUT operand write address.
- dataA/dataB  out  DATA_W  DUT operand write data.
- enA/enB  out  1  DUT operand write enables.
- addrI  out  clog2(INST_DEPTH); dataI  out  INST_W; enI  out  1: DUT instruction write.
- ap_start  out  1  DUT start pulse.
- ap_done  in  1  DUT completion.
- addrO  out  clog2(MAX_N*ROWS*ROWS); dataO  in  OUT_W: DUT result read, latency 1.
- busy, done, pass, timeout  out  1  status.
- match_count  out  clog2(MAX_N*ROWS*ROWS)+1  matching entries.
- first_err_idx  out  clog2(MAX_N*ROWS*ROWS)+1  index of first mismatch.

Function
REQ-008 SHALL map source ROM: A at 0, B at ROWS*DEPTH, instructions at 2*ROWS*DEPTH, expected results at 2*ROWS*DEPTH+INST_DEPTH (low bits used for narrower targets).
REQ-009 SHALL use FSM IDLE->LOAD_A->LOAD_B->LOAD_I->START->WAIT->CHECK->DONE; DONE->IDLE on next go.
REQ-010 SHALL leave IDLE only on go=1; go while busy SHALL be ignored.
REQ-011 SHALL latch n_mat on go, clamped to MAX_N; NRES = n*ROWS*ROWS.
REQ-012 In each LOAD state, src_addr issued at cycle t SHALL appear as one write (en=1, addr=offset, data=src_data) at t+1; LOAD_A/LOAD_B last ROWS*DEPTH+1 cycles, LOAD_I INST_DEPTH+1.
REQ-013 Write enables SHALL be 0 outside their LOAD phase; only one enable high per cycle.
REQ-014 START SHALL drive ap_start=1 exactly one cycle.
REQ-015 ap_done SHALL be ignored outside WAIT; in WAIT, ap_done=1 -> CHECK.
REQ-016 WAIT exceeding TIMEOUT_CYC cycles SHALL go to DONE with timeout=1, pass=0.
REQ-017 CHECK SHALL issue addrO=i and expected src_addr together; compare at i+1; NRES+1 cycles total.
REQ-018 Each equal compare SHALL increment match_count; first mismatch SHALL latch first_err_idx=i.
REQ-019 NRES=0 SHALL skip compares: DONE with pass=1, match_count=0.
REQ-020 In DONE: done=1, pass=(match_count==NRES && !timeout); status held until next go clears it.
REQ-021 busy SHALL be 1 in every state except IDLE and DONE.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, all enables/ap_start/busy/done/pass/timeout to 0, addresses/data/match_count to 0, first_err_idx to all-ones, including mid-operation.

Structure
REQ-023 Package sa_test_pkg SHALL hold state enum, default parameters and source-map base constants.
REQ-024 Compare/count logic SHALL be one sub-module sa_result_cmp (valid, expected, actual -> match_count, first_err_idx).

Verification
REQ-025 n_mat=1, DUT model returns ROM-expected 16 words -> done=1, pass=1, match_count=16.
REQ-026 n_mat=2, word 5 corrupted -> pass=0, match_count=31, first_err_idx=5.
REQ-027 ap_done never asserted, TIMEOUT_CYC=100 -> timeout=1 after 100 WAIT cycles, pass=0.
REQ-028 rst=0 during LOAD_B -> enB=0 same cycle, IDLE, first_err_idx all-ones; next go reloads from address 0.
REQ-029 n_mat=0 -> pass=1, match_count=0, no addrO reads; go pulsed during WAIT -> ignored.
REQ-030 ROWS=8, DEPTH=64 build -> LOAD_A lasts 513 cycles, enA write count 512, n_mat=1 gives match_count=64.
